// File: rtl/flow_led_monitor_if.sv
// Bus between the flowing-light LED driver side and its monitor.
// The master drives the LED pattern and clear pulse; the slave (monitor) returns status.
interface flow_led_monitor_if #(
    parameter int unsigned CNT_W = 32
);
    logic [7:0]       led;
    logic             clear;
    logic [2:0]       pos;
    logic             dir;
    logic             dir_valid;
    logic [CNT_W-1:0] step_period;
    logic             period_valid;
    logic [15:0]      step_count;
    logic             stalled;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output led, clear,
        input  pos, dir, dir_valid, step_period, period_valid,
        input  step_count, stalled, err, err_code
    );

    modport slave (
        input  led, clear,
        output pos, dir, dir_valid, step_period, period_valid,
        output step_count, stalled, err, err_code
    );
endinterface

// File: rtl/flow_led_monitor.sv
// Observer for an 8-bit rotating one-hot LED bus: decodes position, direction,
// step period and count, and flags stalls, non-one-hot samples and jumps.
module flow_led_monitor #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned STALL_LIMIT = 200000000
) (
    input  logic             clk,
    input  logic             rst,
    flow_led_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] STALL_THR  = CNT_W'(STALL_LIMIT);
    localparam logic [15:0]      STEP_MAX   = 16'hFFFF;
    localparam logic [1:0]       ERR_NONE   = 2'b00;
    localparam logic [1:0]       ERR_ONEHOT = 2'b01;
    localparam logic [1:0]       ERR_JUMP   = 2'b10;

    state_e           state_q;
    logic [7:0]       led_q;
    logic [7:0]       prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       pos_q;
    logic             dir_q;
    logic             dir_valid_q;
    logic [CNT_W-1:0] step_period_q;
    logic             period_valid_q;
    logic [15:0]      step_count_q;
    logic             stalled_q;
    logic             err_q;
    logic [1:0]       err_code_q;

    logic             onehot_c;
    logic [2:0]       idx_c;
    logic             left_c;
    logic             right_c;
    logic             adjacent_c;
    logic             changed_c;
    logic             accept_c;
    logic [15:0]      step_count_base_c;
    logic [15:0]      step_count_inc_c;
    logic [1:0]       err_code_base_c;
    logic [1:0]       new_code_c;

    // Decode the sampled pattern relative to the last accepted one.
    always_comb begin
        onehot_c = (led_q != 8'd0) && ((led_q & (led_q - 8'd1)) == 8'd0);
        idx_c    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (led_q[i]) begin
                idx_c = 3'(i);
            end
        end
        left_c     = onehot_c && (led_q == {prev_q[6:0], prev_q[7]});
        right_c    = onehot_c && (led_q == {prev_q[0], prev_q[7:1]});
        adjacent_c = left_c || right_c;
        changed_c  = (led_q != prev_q);
        accept_c   = (state_q == ST_INIT) ? onehot_c : adjacent_c;
        cnt_d      = accept_c ? CNT_W'(1) :
                     ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
        // clear takes effect first so a same-cycle step or error lands on top of it
        step_count_base_c = bus.clear ? 16'd0 : step_count_q;
        step_count_inc_c  = (step_count_base_c == STEP_MAX) ? STEP_MAX
                                                             : step_count_base_c + 16'd1;
        err_code_base_c   = bus.clear ? ERR_NONE : err_code_q;
        new_code_c        = onehot_c ? ERR_JUMP : ERR_ONEHOT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            led_q          <= 8'd0;
            prev_q         <= 8'd0;
            cnt_q          <= '0;
            pos_q          <= 3'd0;
            dir_q          <= 1'b0;
            dir_valid_q    <= 1'b0;
            step_period_q  <= '0;
            period_valid_q <= 1'b0;
            step_count_q   <= 16'd0;
            stalled_q      <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            led_q        <= bus.led;
            cnt_q        <= cnt_d;
            stalled_q    <= (cnt_d >= STALL_THR);
            step_count_q <= step_count_base_c;
            err_q        <= err_q && !bus.clear;
            err_code_q   <= err_code_base_c;
            case (state_q)
                ST_INIT: begin
                    if (onehot_c) begin
                        prev_q  <= led_q;
                        pos_q   <= idx_c;
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC, ST_LOCK: begin
                    if (adjacent_c) begin
                        prev_q       <= led_q;
                        pos_q        <= idx_c;
                        dir_q        <= left_c;
                        dir_valid_q  <= 1'b1;
                        step_count_q <= step_count_inc_c;
                        // first interval after sync is partial, so only LOCK measures it
                        if (state_q == ST_LOCK) begin
                            step_period_q  <= cnt_q;
                            period_valid_q <= 1'b1;
                        end
                        state_q <= ST_LOCK;
                    end else if (changed_c) begin
                        err_q <= 1'b1;
                        if (err_code_base_c == ERR_NONE) begin
                            err_code_q <= new_code_c;
                        end
                        dir_valid_q    <= 1'b0;
                        period_valid_q <= 1'b0;
                        state_q        <= ST_INIT;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign bus.pos          = pos_q;
    assign bus.dir          = dir_q;
    assign bus.dir_valid    = dir_valid_q;
    assign bus.step_period  = step_period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.step_count   = step_count_q;
    assign bus.stalled      = stalled_q;
    assign bus.err          = err_q;
    assign bus.err_code     = err_code_q;
endmodule

// File: tb/tb_flow_led_monitor.sv
// Self-checking bench for flow_led_monitor: directed scenarios then random traffic,
// compared every cycle against a position/timestamp reference model.
module tb_flow_led_monitor;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned LIMIT = 50;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    flow_led_monitor_if #(.CNT_W(CNT_W)) bus ();

    flow_led_monitor #(.CNT_W(CNT_W), .STALL_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks lit index as an integer and step times as edge numbers.
    int         edge_n    = 0;
    logic [7:0] m_sample  = 8'd0;
    bit         m_synced  = 0;
    bit         m_locked  = 0;
    int         m_idx     = 0;
    int         m_acc     = 1;
    logic [2:0] exp_pos   = 3'd0;
    logic       exp_dir   = 1'b0;
    logic       exp_dv    = 1'b0;
    logic [31:0] exp_per  = 32'd0;
    logic       exp_pv    = 1'b0;
    int         exp_cnt   = 0;
    logic       exp_stall = 1'b0;
    logic       exp_err   = 1'b0;
    logic [1:0] exp_code  = 2'b00;

    always @(posedge clk) begin
        logic [7:0] cur;
        int         ones;
        int         ci;
        bit         acc;
        edge_n++;
        if (rst) begin
            m_sample = 8'd0; m_synced = 0; m_locked = 0; m_idx = 0;
            m_acc = edge_n + 1;
            exp_pos = 3'd0; exp_dir = 1'b0; exp_dv = 1'b0; exp_per = 32'd0;
            exp_pv = 1'b0; exp_cnt = 0; exp_err = 1'b0; exp_code = 2'b00;
        end else begin
            cur      = m_sample;
            m_sample = bus.led;
            ones     = $countones(cur);
            ci       = 0;
            for (int i = 0; i < 8; i++) if (cur[i]) ci = i;
            acc = 0;
            if (bus.clear) begin
                exp_err = 1'b0; exp_code = 2'b00; exp_cnt = 0;
            end
            if (!m_synced) begin
                if (ones == 1) begin
                    m_synced = 1; m_locked = 0; m_idx = ci; exp_pos = 3'(ci); acc = 1;
                end
            end else if (ones != 1 || ci != m_idx) begin
                if (ones == 1 && (ci == (m_idx + 1) % 8 || ci == (m_idx + 7) % 8)) begin
                    if (m_locked) begin
                        exp_per = 32'(edge_n - m_acc);
                        exp_pv  = 1'b1;
                    end
                    exp_dir  = (ci == (m_idx + 1) % 8);
                    exp_dv   = 1'b1;
                    exp_cnt  = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
                    m_idx    = ci;
                    exp_pos  = 3'(ci);
                    m_locked = 1;
                    acc      = 1;
                end else begin
                    exp_err = 1'b1;
                    if (exp_code == 2'b00) exp_code = (ones == 1) ? 2'b10 : 2'b01;
                    exp_dv   = 1'b0;
                    exp_pv   = 1'b0;
                    m_synced = 0;
                    m_locked = 0;
                end
            end
            if (acc) m_acc = edge_n;
        end
        exp_stall = ((edge_n - m_acc + 1) >= int'(LIMIT));
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pos",          64'(bus.pos),          64'(exp_pos));
        chk("dir",          64'(bus.dir),          64'(exp_dir));
        chk("dir_valid",    64'(bus.dir_valid),    64'(exp_dv));
        chk("step_period",  64'(bus.step_period),  64'(exp_per));
        chk("period_valid", 64'(bus.period_valid), 64'(exp_pv));
        chk("step_count",   64'(bus.step_count),   64'(exp_cnt));
        chk("stalled",      64'(bus.stalled),      64'(exp_stall));
        chk("err",          64'(bus.err),          64'(exp_err));
        chk("err_code",     64'(bus.err_code),     64'(exp_code));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        logic [7:0] cur;
        int         r;
        rst       = 1'b1;
        bus.led   = 8'h01;
        bus.clear = 1'b0;
        tick(3);
        chk("reset_pos", 64'(bus.pos), 64'd0);
        chk("reset_err", 64'(bus.err), 64'd0);
        rst = 1'b0;

        // left steps every 10 cycles
        tick(10);
        bus.led = 8'h02; tick(10);
        bus.led = 8'h04; tick(10);
        chk("t1_pos", 64'(bus.pos), 64'd2);
        chk("t1_dir", 64'(bus.dir), 64'd1);
        chk("t1_period", 64'(bus.step_period), 64'd10);
        chk("t1_pv", 64'(bus.period_valid), 64'd1);
        chk("t1_count", 64'(bus.step_count), 64'd2);

        // right rotation through the wrap, then left wrap back
        bus.led = 8'h02; tick(6);
        bus.led = 8'h01; tick(6);
        bus.led = 8'h80; tick(6);
        bus.led = 8'h40; tick(6);
        chk("t2_pos", 64'(bus.pos), 64'd6);
        chk("t2_dir", 64'(bus.dir), 64'd0);
        chk("t2_period", 64'(bus.step_period), 64'd6);
        bus.led = 8'h80; tick(6);
        bus.led = 8'h01; tick(6);
        chk("t2_wrap_pos", 64'(bus.pos), 64'd0);
        chk("t2_wrap_dir", 64'(bus.dir), 64'd1);

        // reversal
        bus.led = 8'h02; tick(4);
        bus.led = 8'h04; tick(4);
        bus.led = 8'h08; tick(4);
        chk("t3_dir_l", 64'(bus.dir), 64'd1);
        bus.led = 8'h04; tick(4);
        chk("t3_dir_r", 64'(bus.dir), 64'd0);
        chk("t3_err", 64'(bus.err), 64'd0);

        // illegal patterns
        bus.led = 8'h02; tick(4);
        bus.led = 8'h03; tick(4);
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_code", 64'(bus.err_code), 64'd1);
        chk("t4_dv", 64'(bus.dir_valid), 64'd0);
        bus.led = 8'h01; tick(4);
        bus.led = 8'h10; tick(4);
        chk("t4_code_sticky", 64'(bus.err_code), 64'd1);
        bus.clear = 1'b1; tick(1);
        bus.clear = 1'b0; tick(1);
        chk("t4_clr_err", 64'(bus.err), 64'd0);
        chk("t4_clr_code", 64'(bus.err_code), 64'd0);
        chk("t4_clr_count", 64'(bus.step_count), 64'd0);

        // stall then recovery
        bus.led = 8'h20; tick(70);
        chk("t5_stalled", 64'(bus.stalled), 64'd1);
        bus.led = 8'h40; tick(2);
        chk("t5_unstall", 64'(bus.stalled), 64'd0);
        chk("t5_period", 64'(bus.step_period), 64'd70);

        // clear coincident with a step, then reset while locked
        bus.led = 8'h80; tick(1);
        bus.clear = 1'b1; tick(1);
        bus.clear = 1'b0;
        chk("t6_count", 64'(bus.step_count), 64'd1);
        tick(3);
        rst = 1'b1; tick(1);
        chk("t6_rst_dv", 64'(bus.dir_valid), 64'd0);
        chk("t6_rst_count", 64'(bus.step_count), 64'd0);
        chk("t6_rst_pos", 64'(bus.pos), 64'd0);
        rst = 1'b0; tick(2);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            cur = bus.led;
            r   = int'($urandom_range(0, 19));
            if (r < 8)       bus.led = {cur[6:0], cur[7]};
            else if (r < 14) bus.led = {cur[0], cur[7:1]};
            else if (r == 14) bus.led = 8'($urandom);
            else if (r == 15) bus.led = 8'h01 << $urandom_range(0, 7);
            if (r == 16) bus.clear = 1'b1;
            if (r == 17) tick(int'($urandom_range(45, 60)));
            else         tick(int'($urandom_range(1, 4)));
            bus.clear = 1'b0;
        end
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flow_led_monitor.md
Name: flow_led_monitor

Overview:
Observer/checker for the 8-bit flowing-light LED bus. It samples the `led` vector and decodes the lit position. It also infers rotation direction, measures step period in clock cycles, counts steps, and detects stalls and illegal patterns. The block sits beside the light driver, on the board or in the testbench, and feeds debug displays and self-check logic.

Parameters:
CNT_W, 32, width of period/stall counter (saturating)
STALL_LIMIT, 200000000, cycles without an accepted step before `stalled` asserts

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
led  input  8  observed LED pattern, synchronous to clk
clear  input  1  one-cycle pulse; clears err, err_code, step_count
pos  output  3  index of lit bit in last accepted one-hot sample
dir  output  1  1 = left (led[i] -> led[i+1], bit7 -> bit0 wraps); 0 = right
dir_valid  output  1  a direction has been inferred since last sync
step_period  output  CNT_W  cycles between the last two accepted steps
period_valid  output  1  step_period holds a real measurement
step_count  output  16  accepted steps, saturates at 16'hFFFF
stalled  output  1  no accepted step for >= STALL_LIMIT cycles
err  output  1  sticky error flag
err_code  output  2  first error since clear: 00 none, 01 not one-hot, 10 non-adjacent jump

Behaviour:
- Reset values: pos=0, dir=0, dir_valid=0, step_period=0, period_valid=0, step_count=0, stalled=0, err=0, err_code=00, state=INIT, internal counter=0.
- Input stage: `led_q <= led` every cycle. All decisions compare `led_q` against `prev`, the last accepted sample.
- Latency: outputs update on the 2nd clk edge after `led` changes.
- Adjacent step: `led_q` is one-hot and equals `prev` rotated by one.
  - Left = `{prev[6:0],prev[7]}`.
  - Right = `{prev[0],prev[7:1]}`.
  - Wrap in both directions counts as adjacent.
- Counter: on an accepted step, `cnt <= 1`; otherwise `cnt <= cnt+1`, saturating at all-ones. `stalled = (cnt >= STALL_LIMIT)`. `stalled` clears on the next accepted step.
- State INIT: wait for one-hot `led_q`.
  - On one-hot `led_q`: `prev <= led_q`, `pos <= index`, `cnt <= 1`, go SYNC.
  - Non-one-hot `led_q` in INIT (e.g. all-zero) is ignored, with no error.
- State SYNC: first step seen, direction unknown.
  - `led_q == prev`: hold.
  - Adjacent step: set `dir`, `dir_valid=1`, `step_count+1`, update `pos`/`prev`, go LOCK. `period_valid` stays 0, because the first interval is partial.
- State LOCK:
  - Adjacent step in either direction: `step_period <= cnt`, `period_valid=1`, `step_count+1`, update `pos`/`prev`/`dir`. A direction reversal is legal and simply updates `dir`.
- Error, in SYNC or LOCK, when `led_q != prev`:
  - `led_q` not one-hot -> code 01.
  - `led_q` one-hot but non-adjacent -> code 10.
  - Action: `err=1`; `err_code` is written only if it is currently 00.
  - Resync: `dir_valid=0`, `period_valid=0`, go INIT. The same `led_q` is re-evaluated by INIT on the next cycle.
- `clear`:
  - Zeroes `err`, `err_code`, `step_count`.
  - A step in the same cycle gives `step_count=1`.
  - An error in the same cycle wins: `err=1` with the new code.
- `rst` mid-operation returns everything to reset values on that edge, regardless of state.
- `step_count` saturation: stays 16'hFFFF; does not wrap.

Test Plan:
1. Reset, `led=8'h01` held; then left steps 01->02->04 every 10 cycles -> after 2nd step: pos=2, dir=1, dir_valid=1, step_period=10, period_valid=1, step_count=2, err=0.
2. Wrap with right rotation: 01 -> 80 -> 40 at 6-cycle spacing -> pos=6, dir=0, step_period=6. Then left wrap 80 -> 01 -> pos=0, dir=1.
3. Direction reversal mid-run: 04 -> 08 -> 04 -> dir goes 1 then 0, err=0, step_count increments each step.
4. Illegal patterns:
   - `led` 02 -> 03 -> err=1, err_code=01, dir_valid=0, state INIT, then resync on next one-hot.
   - Next, 01 -> 10 jump -> err stays 1, err_code stays 01.
   - Pulse `clear` -> err=0, err_code=00, step_count=0.
5. Stall with STALL_LIMIT=50: hold `led` 70 cycles after a step -> stalled=1 from cycle 50 after the step; the next adjacent step drops stalled to 0 with step_period=cnt.
6. Simultaneous events:
   - `clear` coincident with a step -> step_count=1.
   - `rst` asserted while in LOCK -> all outputs at reset values next edge.
